// File: rtl/out_pack_pkg.sv
// Purpose: shared constants and queue-entry layout for the output requantise/pack block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package out_pack_pkg;

  localparam int OUT_MAX   = 255;
  localparam int MAX_SHIFT = 24;

  // Entry geometry; must agree with the OUT_W/PACK parameters of out_requant_pack.
  localparam int ENT_OUT_W = 8;
  localparam int ENT_PACK  = 4;

  typedef struct packed {
    logic [ENT_PACK*ENT_OUT_W-1:0] data;
    logic [ENT_PACK-1:0]           keep;
    logic                          last;
  } q_entry_t;

endpackage

// File: rtl/out_word_q.sv
// Purpose: small synchronous word FIFO holding packed output words; head is shown combinationally.
// Latency: a word pushed at edge E is visible at the head after E (if the queue was empty).
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk/rst (sync, active-high), push/push_dat, pop, head_dat, full, empty, count.
module out_word_q #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [W-1:0]                   push_dat,
  input  logic                           pop,
  output logic [W-1:0]                   head_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_requant_pack.sv
// Purpose: requantise post-ReLU results to 8 bits (round-half-up shift, saturate) and pack PACK per word.
// Latency: element accepted at E0 is packed at E1; a completed word shows on out_* the cycle after E1.
// Backpressure: valid/ready on the output; upstream throttled via stall_req, overflow_err if input dropped.
// Ports: clk, rst, stall, in_valid/in_data/row_last, shift, out_valid/out_data/out_keep/out_last/out_ready,
//        stall_req, busy, overflow_err.
module out_requant_pack
  import out_pack_pkg::*;
#(
  parameter int IN_W    = 25,
  parameter int OUT_W   = 8,
  parameter int PACK    = 4,
  parameter int SHIFT_W = 5,
  parameter int Q_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    in_valid,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    row_last,
  input  logic [SHIFT_W-1:0]      shift,
  output logic                    out_valid,
  output logic [PACK*OUT_W-1:0]   out_data,
  output logic [PACK-1:0]         out_keep,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    stall_req,
  output logic                    busy,
  output logic                    overflow_err
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = $clog2(Q_DEPTH+1);

  // Stage 1 (quantised element) and stage 2 (pack accumulator) state.
  logic                  s1_vld;
  logic [OUT_W-1:0]      s1_q;
  logic                  s1_last;
  logic [PACK*OUT_W-1:0] acc;
  logic [PACK-1:0]       keep;
  logic [LW-1:0]         lane_cnt;

  // Quantiser datapath.
  logic [IN_W-1:0]       x;
  logic [SHIFT_W-1:0]    sh;
  logic [IN_W:0]         rnd;
  logic [IN_W:0]         r;
  logic [OUT_W-1:0]      q;

  // Pack / queue control.
  logic [PACK*OUT_W-1:0] acc_nxt;
  logic [PACK-1:0]       keep_nxt;
  logic                  complete;
  logic                  hold;
  logic                  advance;
  logic                  push;
  logic                  pop;
  q_entry_t              push_ent;
  q_entry_t              head_ent;
  logic                  q_full;
  logic                  q_empty;
  logic [CW-1:0]         q_count;

  always_comb begin
    // Negative values cannot legally arrive after ReLU; clamp them to zero anyway.
    x   = in_data[IN_W-1] ? '0 : in_data;
    sh  = (shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift;
    rnd = '0;
    if (sh != '0) rnd = (IN_W+1)'(1) << (sh - SHIFT_W'(1));
    // One extra bit of headroom so the rounding add never wraps.
    r   = ({1'b0, x} + rnd) >> sh;
    q   = (|r[IN_W:OUT_W]) ? OUT_W'(OUT_MAX) : r[OUT_W-1:0];
  end

  always_comb begin
    acc_nxt                            = acc;
    acc_nxt[lane_cnt*OUT_W +: OUT_W]   = s1_q;
    keep_nxt                           = keep;
    keep_nxt[lane_cnt]                 = 1'b1;
    complete = s1_vld & ((lane_cnt == LW'(PACK-1)) | s1_last);
    pop      = out_valid & out_ready;
    // A completing word with nowhere to go freezes both stages until a slot opens.
    hold     = complete & q_full & ~pop;
    advance  = ~stall & ~hold;
    push     = advance & complete;
    push_ent = '{data: acc_nxt, keep: keep_nxt, last: s1_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      s1_q         <= '0;
      s1_last      <= 1'b0;
      acc          <= '0;
      keep         <= '0;
      lane_cnt     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (advance) begin
        s1_vld  <= in_valid;
        s1_q    <= q;
        s1_last <= row_last & in_valid;
        if (s1_vld) begin
          if (complete) begin
            acc      <= '0;
            keep     <= '0;
            lane_cnt <= '0;
          end else begin
            acc      <= acc_nxt;
            keep     <= keep_nxt;
            lane_cnt <= lane_cnt + LW'(1);
          end
        end
      end
      if (in_valid & ~stall & hold) overflow_err <= 1'b1;
    end
  end

  out_word_q #(
    .DEPTH (Q_DEPTH),
    .W     ($bits(q_entry_t))
  ) u_word_q (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // Stale queue storage is masked so outputs read zero whenever nothing is offered.
  assign out_valid = ~q_empty;
  assign out_data  = q_empty ? '0 : head_ent.data;
  assign out_keep  = q_empty ? '0 : head_ent.keep;
  assign out_last  = q_empty ? 1'b0 : head_ent.last;
  assign stall_req = (q_count == CW'(Q_DEPTH)) | hold;
  assign busy      = s1_vld | (lane_cnt != '0) | (q_count != '0);

endmodule

// File: tb/tb_out_requant_pack.sv
module tb_out_requant_pack;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } wrd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        stall_drv;
  logic        stall_follow;
  logic        in_valid;
  logic [24:0] in_data;
  logic        row_last;
  logic [4:0]  shift;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_ready;
  logic        stall_req;
  logic        busy;
  logic        overflow_err;

  int   errors = 0;
  int   checks = 0;
  bit   rand_ready = 0;
  wrd_t exp_q[$];
  wrd_t obs_q[$];
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  int          m_lane;

  assign stall = stall_follow ? stall_req : stall_drv;

  always #5 clk = ~clk;

  out_requant_pack dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .row_last     (row_last),
    .shift        (shift),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .stall_req    (stall_req),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  // Collect every word the consumer takes; pop happens at the following posedge.
  always @(negedge clk)
    if (!rst && out_valid && out_ready) obs_q.push_back('{out_data, out_keep, out_last});

  // Reference: round-half-up division by 2^shift, saturated to 255.
  function automatic int ref_q(input int x, input int sh);
    int s;
    int r;
    if (x >= (1 << 24)) x = 0;
    s = (sh > 24) ? 24 : sh;
    r = (s == 0) ? x : (x + (1 << s) / 2) / (1 << s);
    return (r > 255) ? 255 : r;
  endfunction

  task automatic mdl_clear();
    exp_q.delete();
    obs_q.delete();
    m_data = '0;
    m_keep = '0;
    m_lane = 0;
  endtask

  task automatic mdl_add(input int q, input bit l);
    m_data[m_lane*8 +: 8] = q[7:0];
    m_keep[m_lane] = 1'b1;
    if (m_lane == 3 || l) begin
      exp_q.push_back('{m_data, m_keep, l});
      m_data = '0;
      m_keep = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    row_last = 0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic v, input logic [24:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    row_last = l;
    tick();
    in_valid = 0;
    row_last = 0;
  endtask

  // Present one element until the block takes it (stall low at the edge).
  task automatic feed(input logic [24:0] d, input logic l);
    bit acc = 0;
    in_valid = 1;
    in_data  = d;
    row_last = l;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = !stall;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (acc) mdl_add(ref_q(int'(d), int'(shift)), l);
    else begin
      errors++;
      $display("FAIL feed_accept: element %h never accepted", d);
    end
    in_valid = 0;
    row_last = 0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid   = 0;
    row_last   = 0;
    rand_ready = 0;
    out_ready  = 1;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_busy: busy=%b want 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    checks += 7;
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_data !== 32'h0)    begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    if (out_keep !== 4'h0)     begin errors++; $display("FAIL rst_out_keep: got %b want 0", out_keep); end
    if (out_last !== 1'b0)     begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    if (stall_req !== 1'b0)    begin errors++; $display("FAIL rst_stall_req: got %b want 0", stall_req); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow_err); end
  endtask

  task automatic test_basic_pack();
    mdl_clear();
    shift = 4;
    out_ready = 1;
    feed(16, 0);
    feed(24, 0);
    feed(40, 0);
    feed(4095, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid=%b want 0 one cycle after input", out_valid); end
    tick();
    checks += 4;
    if (out_valid !== 1'b1)       begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    if (out_data !== 32'hFF030201) begin errors++; $display("FAIL basic_data: got %h want ff030201", out_data); end
    if (out_keep !== 4'b1111)     begin errors++; $display("FAIL basic_keep: got %b want 1111", out_keep); end
    if (out_last !== 1'b0)        begin errors++; $display("FAIL basic_last: got %b want 0", out_last); end
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      begin errors++; $display("FAIL basic_model: got %0d words first %h want 1 word %h", obs_q.size(), obs_q[0], exp_q[0]); end
  endtask

  task automatic test_row_flush();
    mdl_clear();
    shift = 0;
    feed(7, 0);
    feed(300, 1);
    feed(5, 1);
    drain();
    checks += 3;
    if (obs_q.size() != 2) begin errors++; $display("FAIL flush_count: got %0d words want 2", obs_q.size()); end
    if (obs_q[0] !== {32'h0000FF07, 4'b0011, 1'b1})
      begin errors++; $display("FAIL flush_word: got %h want %h", obs_q[0], {32'h0000FF07, 4'b0011, 1'b1}); end
    if (obs_q[1] !== {32'h00000005, 4'b0001, 1'b1})
      begin errors++; $display("FAIL flush_next_lane0: got %h want %h", obs_q[1], {32'h00000005, 4'b0001, 1'b1}); end
  endtask

  task automatic test_backpressure();
    mdl_clear();
    shift = 5'($urandom_range(0, 24));
    stall_follow = 1;
    out_ready = 0;
    for (int i = 0; i < 8; i++) feed(25'($urandom_range(0, 32'h0FF_FFFF)), 0);
    idle(3);
    checks += 3;
    if (stall_req !== 1'b1)    begin errors++; $display("FAIL bp_stall_req: got %b want 1 with 2 words queued", stall_req); end
    if (out_valid !== 1'b1)    begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL bp_no_drop: overflow_err=%b want 0", overflow_err); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) feed(25'($urandom_range(0, 32'h0FF_FFFF)), 0);
    drain();
    checks += 2;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL bp_overflow_end: got %b want 0", overflow_err); end
    if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL bp_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    else
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    stall_follow = 0;
  endtask

  task automatic test_drop();
    mdl_clear();
    shift = 0;
    stall_follow = 0;
    stall_drv = 0;
    out_ready = 0;
    for (int i = 0; i < 12; i++) drive(1, 25'(i + 1), 0);
    checks += 2;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL drop_before: overflow_err=%b want 0", overflow_err); end
    if (stall_req !== 1'b1)    begin errors++; $display("FAIL drop_stall_req: got %b want 1", stall_req); end
    drive(1, 13, 0);
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL drop_detect: overflow_err=%b want 1", overflow_err); end
    drain();
    checks += 3;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: overflow_err=%b want 1", overflow_err); end
    if (obs_q.size() != 3)     begin errors++; $display("FAIL drop_count: got %0d words want 3", obs_q.size()); end
    else if (obs_q[2] !== {32'h0C0B0A09, 4'b1111, 1'b0})
      begin errors++; $display("FAIL drop_word3: got %h want %h", obs_q[2], {32'h0C0B0A09, 4'b1111, 1'b0}); end
    rst = 1;
    tick();
    rst = 0;
    tick();
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL drop_rst_clear: overflow_err=%b want 0", overflow_err); end
  endtask

  task automatic test_stall_mid_word();
    mdl_clear();
    shift = 0;
    stall_follow = 0;
    stall_drv = 0;
    out_ready = 1;
    feed(1, 0);
    feed(2, 0);
    stall_drv = 1;
    for (int i = 0; i < 5; i++) drive(1, 25'h55, 1);
    stall_drv = 0;
    feed(3, 0);
    feed(4, 0);
    drain();
    checks += 2;
    if (obs_q.size() != 1) begin errors++; $display("FAIL stall_count: got %0d words want 1", obs_q.size()); end
    if (obs_q[0] !== {32'h04030201, 4'b1111, 1'b0})
      begin errors++; $display("FAIL stall_word: got %h want %h", obs_q[0], {32'h04030201, 4'b1111, 1'b0}); end
  endtask

  task automatic test_reset_mid_word();
    shift = 0;
    out_ready = 1;
    feed(9, 0);
    feed(10, 0);
    feed(11, 0);
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_cleared: got %b want 0", busy); end
    mdl_clear();
    shift = 16;
    feed(25'h1_0000, 1);
    drain();
    checks += 3;
    if (obs_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d words want 1", obs_q.size()); end
    if (obs_q[0] !== {32'h00000001, 4'b0001, 1'b1})
      begin errors++; $display("FAIL rstmid_word: got %h want %h", obs_q[0], {32'h00000001, 4'b0001, 1'b1}); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_sign_and_big_shift();
    mdl_clear();
    out_ready = 1;
    shift = 0;
    feed(25'h100_0005, 0);
    feed(25'h1FF_FFFF, 1);
    drain();
    shift = 31;
    feed(25'h0FF_FFFF, 1);
    drain();
    checks += 2;
    if (obs_q[0] !== {32'h00000000, 4'b0011, 1'b1})
      begin errors++; $display("FAIL sign_guard: got %h want %h", obs_q[0], {32'h00000000, 4'b0011, 1'b1}); end
    if (obs_q[1] !== {32'h00000001, 4'b0001, 1'b1})
      begin errors++; $display("FAIL shift_sat: got %h want %h", obs_q[1], {32'h00000001, 4'b0001, 1'b1}); end
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 4; rep++) begin
      mdl_clear();
      shift = 5'($urandom_range(0, 31));
      stall_follow = 1;
      rand_ready = 1;
      for (int i = 0; i < 30; i++) begin
        logic [24:0] d;
        case ($urandom_range(0, 3))
          0:       d = 25'($urandom_range(0, 1023));
          1:       d = 25'($urandom);
          2:       d = 25'($urandom_range(0, 32'h0FF_FFFF));
          default: d = 25'((($urandom_range(0, 300)) << shift) | ((32'd1 << shift) >> 1));
        endcase
        feed(d, (i == 29) || ($urandom_range(0, 5) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      drain();
      stall_follow = 0;
      checks++;
      if (obs_q.size() != exp_q.size())
        begin errors++; $display("FAIL rand%0d_count: got %0d words want %0d", rep, obs_q.size(), exp_q.size()); end
      else
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i])
            begin errors++; $display("FAIL rand%0d_word%0d: got %h want %h", rep, i, obs_q[i], exp_q[i]); end
        end
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    stall_drv = 0;
    stall_follow = 0;
    in_valid = 0;
    in_data = '0;
    row_last = 0;
    shift = '0;
    out_ready = 0;
    test_reset();
    test_basic_pack();
    test_row_flush();
    test_backpressure();
    test_drop();
    test_stall_mid_word();
    test_reset_mid_word();
    test_sign_and_big_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
